// File: rtl/vdp_cpu_ifce_pkg.sv
// Shared definitions for the VDP CPU port: control codes, FSM encodings,
// byte sequencer states and the address-setup record passed to the VRAM port.
package vdp_cpu_ifce_pkg;

    localparam logic [1:0] CMD_REG   = 2'b10;
    localparam logic [1:0] CMD_WADDR = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b00;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;

    localparam logic SEQ_FIRST  = 1'b0;
    localparam logic SEQ_SECOND = 1'b1;

    localparam int MAX_AW = 14;

    // load: replace the VRAM address; read: also issue a read at that address
    typedef struct packed {
        logic              load;
        logic              read;
        logic [MAX_AW-1:0] value;
    } addr_setup_t;

    function automatic logic [MAX_AW-1:0] setup_addr(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[5:0], lo};
    endfunction

endpackage

// File: rtl/vdp_vram_port.sv
// VRAM request FSM with auto-incrementing address and the CPU read-ahead buffer.
// One access in flight at a time; anything arriving while busy is dropped and flagged.
module vdp_vram_port
    import vdp_cpu_ifce_pkg::*;
#(
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr0_tick,
    input  logic               rd0_tick,
    input  logic [7:0]         din,
    input  addr_setup_t        setup,
    output logic [7:0]         rd_data,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic               overrun
);

    logic [1:0]         state;
    logic [VRAM_AW-1:0] addr_q;
    logic [VRAM_AW-1:0] addr_base;
    logic               request;

    // A setup in the same cycle takes effect before the access or increment uses it
    assign addr_base = setup.load ? setup.value[VRAM_AW-1:0] : addr_q;
    assign request   = wr0_tick | rd0_tick | setup.read;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            rd_data    <= '0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            overrun    <= 1'b0;
        end else begin
            if (setup.load) addr_q <= addr_base;
            case (state)
                ST_IDLE: begin
                    if (wr0_tick) begin
                        state      <= ST_WR;
                        vram_addr  <= addr_base;
                        vram_wdata <= din;
                        rd_data    <= din;
                    end else if (rd0_tick | setup.read) begin
                        state     <= ST_RD;
                        vram_addr <= addr_base;
                    end
                end
                ST_RD: begin
                    if (request) overrun <= 1'b1;
                    if (vram_ack) begin
                        rd_data <= vram_rdata;
                        addr_q  <= addr_base + VRAM_AW'(1);
                        state   <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (request) overrun <= 1'b1;
                    if (vram_ack) begin
                        addr_q <= addr_base + VRAM_AW'(1);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign vram_req = (state != ST_IDLE);
    assign vram_we  = (state == ST_WR);

endmodule

// File: rtl/vdp_cpu_ifce.sv
// CPU-side VDP port: two-byte control sequencer and config register file,
// with VRAM data traffic delegated to vdp_vram_port.
module vdp_cpu_ifce
    import vdp_cpu_ifce_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int VRAM_AW  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_tick,
    input  logic                  rd0_tick,
    input  logic                  wr1_tick,
    input  logic                  rd1_tick,
    input  logic [7:0]            din,
    output logic [7:0]            rd_data,
    output logic [8*NUM_REGS-1:0] regs,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    output logic                  busy,
    output logic                  overrun
);

    logic        seq;
    logic [7:0]  w0;
    logic [7:0]  reg_q [NUM_REGS];
    logic        second_wr;
    logic [1:0]  cmd;
    addr_setup_t setup;

    // A status read in the same cycle cancels the control write outright
    assign second_wr = wr1_tick & ~rd1_tick & (seq == SEQ_SECOND);
    assign cmd       = din[7:6];

    always_comb begin
        setup       = '0;
        setup.value = setup_addr(din, w0);
        setup.load  = second_wr & ((cmd == CMD_WADDR) | (cmd == CMD_RADDR));
        setup.read  = second_wr & (cmd == CMD_RADDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= SEQ_FIRST;
            w0  <= '0;
            for (int n = 0; n < NUM_REGS; n++) reg_q[n] <= '0;
        end else if (rd1_tick) begin
            seq <= SEQ_FIRST;
        end else if (wr1_tick) begin
            if (seq == SEQ_FIRST) begin
                w0  <= din;
                seq <= SEQ_SECOND;
            end else begin
                seq <= SEQ_FIRST;
                if (cmd == CMD_REG) begin
                    for (int n = 0; n < NUM_REGS; n++)
                        if (din[5:0] == 6'(n)) reg_q[n] <= w0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[8*g +: 8] = reg_q[g];
    end

    vdp_vram_port #(
        .VRAM_AW(VRAM_AW)
    ) u_vram_port (
        .clk        (clk),
        .reset      (reset),
        .wr0_tick   (wr0_tick),
        .rd0_tick   (rd0_tick),
        .din        (din),
        .setup      (setup),
        .rd_data    (rd_data),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .overrun    (overrun)
    );

    assign busy = vram_req;

endmodule

// File: tb/tb_vdp_cpu_ifce.sv
// Bench for vdp_cpu_ifce: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_vdp_cpu_ifce;

    localparam int NUM_REGS = 8;
    localparam int VRAM_AW  = 14;
    localparam int VSIZE    = 1 << VRAM_AW;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr0_tick, rd0_tick, wr1_tick, rd1_tick;
    logic [7:0]            din;
    logic [7:0]            rd_data;
    logic [8*NUM_REGS-1:0] regs;
    logic                  vram_req, vram_we;
    logic [VRAM_AW-1:0]    vram_addr;
    logic [7:0]            vram_wdata;
    logic                  vram_ack;
    logic [7:0]            vram_rdata;
    logic                  busy, overrun;

    int n_checks = 0;
    int n_errors = 0;

    vdp_cpu_ifce #(.NUM_REGS(NUM_REGS), .VRAM_AW(VRAM_AW)) dut (
        .clk(clk), .reset(reset),
        .wr0_tick(wr0_tick), .rd0_tick(rd0_tick), .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
        .din(din), .rd_data(rd_data), .regs(regs),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0; vram_ack = 0;
    endtask

    function automatic logic [7:0] reg_of(input int idx);
        return regs[8*idx +: 8];
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr0, rd0, wr1, rd1, ack;
        logic [7:0]  din, rdata;
        logic        req, we;
        logic [13:0] vaddr;
        logic [7:0]  wdata, rd;
        logic        ovr;
        int          ridx;
        logic [7:0]  rval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr0, rd0, wr1, rd1, ack,
                                input logic [7:0] d, rdt,
                                input logic req, we, input logic [13:0] va,
                                input logic [7:0] wd, rd, input logic ovr,
                                input int ridx, input logic [7:0] rval);
        vec_t v;
        v.wr0 = wr0; v.rd0 = rd0; v.wr1 = wr1; v.rd1 = rd1; v.ack = ack;
        v.din = d; v.rdata = rdt; v.req = req; v.we = we; v.vaddr = va;
        v.wdata = wd; v.rd = rd; v.ovr = ovr; v.ridx = ridx; v.rval = rval;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]         mem [VSIZE];
    logic [7:0]         m_regs [NUM_REGS];
    logic               m_first, m_busy, m_pwrite, m_ovr;
    logic [7:0]         m_w0, m_rd, m_pdata;
    int                 m_addr, m_paddr;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
        m_first = 1; m_busy = 0; m_pwrite = 0; m_ovr = 0;
        m_w0 = 0; m_rd = 0; m_pdata = 0; m_addr = 0; m_paddr = 0;
    endtask

    // Advance the model by one clock given the inputs currently applied
    task automatic model_step();
        bit ld, rs;
        int nv, idx;
        ld = 0; rs = 0; nv = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (rd1_tick) m_first = 1;
        else if (wr1_tick) begin
            if (m_first) begin
                m_w0 = din; m_first = 0;
            end else begin
                m_first = 1;
                idx = int'(din[5:0]);
                if (din[7:6] == 2'b10 && idx < NUM_REGS) m_regs[idx] = m_w0;
                if (din[7:6] == 2'b01 || din[7:6] == 2'b00) begin
                    ld = 1;
                    nv = (int'(din[5:0]) * 256 + int'(m_w0)) % VSIZE;
                end
                rs = (din[7:6] == 2'b00);
            end
        end
        if (m_busy) begin
            if (wr0_tick || rd0_tick || rs) m_ovr = 1;
            if (ld) m_addr = nv;
            if (vram_ack) begin
                if (m_pwrite) mem[m_paddr] = m_pdata;
                else m_rd = mem[m_paddr];
                m_addr = (m_addr + 1) % VSIZE;
                m_busy = 0;
            end
        end else begin
            if (ld) m_addr = nv;
            if (wr0_tick) begin
                m_busy = 1; m_pwrite = 1; m_paddr = m_addr; m_pdata = din; m_rd = din;
            end else if (rd0_tick || rs) begin
                m_busy = 1; m_pwrite = 0; m_paddr = m_addr;
            end
        end
    endtask

    task automatic model_compare();
        logic [8*NUM_REGS-1:0] er;
        for (int i = 0; i < NUM_REGS; i++) er[8*i +: 8] = m_regs[i];
        chk("rnd_req", {63'd0, vram_req}, {63'd0, m_busy});
        chk("rnd_busy", {63'd0, busy}, {63'd0, m_busy});
        if (m_busy) begin
            chk("rnd_we", {63'd0, vram_we}, {63'd0, m_pwrite});
            chk("rnd_vaddr", 64'(vram_addr), 64'(m_paddr));
            if (m_pwrite) chk("rnd_wdata", 64'(vram_wdata), 64'(m_pdata));
        end
        chk("rnd_rd_data", 64'(rd_data), 64'(m_rd));
        chk("rnd_overrun", {63'd0, overrun}, {63'd0, m_ovr});
        chk("rnd_regs", 64'(regs), 64'(er));
    endtask

    initial begin
        reset = 1; wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0;
        din = 0; vram_ack = 0; vram_rdata = 0;
        for (int i = 0; i < VSIZE; i++) mem[i] = 8'($urandom);
        cyc(); cyc();
        reset = 0;
        chk("reset_req", {63'd0, vram_req}, 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_regs", 64'(regs), 64'd0);
        chk("reset_overrun", {63'd0, overrun}, 64'd0);

        //            wr0 rd0 wr1 rd1 ack din    rdata  req we vaddr     wdata  rd     ovr ridx rval
        vecs.push_back(mk(0,0,1,0,0, 8'h5A, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 3, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h83, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 3, 8'h5A));
        vecs.push_back(mk(0,0,1,0,0, 8'h11, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h89, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h34, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 3, 8'h5A));
        vecs.push_back(mk(0,0,1,0,0, 8'h52, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 0, 2, 8'h00));
        vecs.push_back(mk(1,0,0,0,0, 8'hAB, 8'h00, 1,1, 14'h1234, 8'hAB, 8'hAB, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 8'h00, 1,1, 14'h1234, 8'hAB, 8'hAB, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h00, 0,0, 14'h0000, 8'h00, 8'hAB, 0, -1, 8'h00));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 8'h00, 1,0, 14'h1235, 8'h00, 8'hAB, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'hC3, 0,0, 14'h0000, 8'h00, 8'hC3, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'hFF, 8'h00, 0,0, 14'h0000, 8'h00, 8'hC3, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h3F, 8'h00, 1,0, 14'h3FFF, 8'h00, 8'hC3, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h77, 0,0, 14'h0000, 8'h00, 8'h77, 0, -1, 8'h00));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 8'h00, 1,0, 14'h0000, 8'h00, 8'h77, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h66, 0,0, 14'h0000, 8'h00, 8'h66, 0, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h99, 0,0, 14'h0000, 8'h00, 8'h66, 0, -1, 8'h00));
        vecs.push_back(mk(1,0,0,0,0, 8'h10, 8'h00, 1,1, 14'h0001, 8'h10, 8'h10, 0, -1, 8'h00));
        vecs.push_back(mk(1,0,0,0,0, 8'h20, 8'h00, 1,1, 14'h0001, 8'h10, 8'h10, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h00, 0,0, 14'h0000, 8'h00, 8'h10, 1, -1, 8'h00));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 8'h00, 1,0, 14'h0002, 8'h00, 8'h10, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h5E, 0,0, 14'h0000, 8'h00, 8'h5E, 1, -1, 8'h00));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 8'h00, 1,0, 14'h0003, 8'h00, 8'h5E, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h21, 8'h00, 1,0, 14'h0003, 8'h00, 8'h5E, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,1,0,0, 8'h45, 8'h00, 1,0, 14'h0003, 8'h00, 8'h5E, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h3C, 0,0, 14'h0000, 8'h00, 8'h3C, 1, -1, 8'h00));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 8'h00, 1,0, 14'h0522, 8'h00, 8'h3C, 1, -1, 8'h00));
        vecs.push_back(mk(0,0,0,0,1, 8'h00, 8'h00, 0,0, 14'h0000, 8'h00, 8'h00, 1, -1, 8'h00));

        foreach (vecs[k]) begin
            wr0_tick = vecs[k].wr0; rd0_tick = vecs[k].rd0;
            wr1_tick = vecs[k].wr1; rd1_tick = vecs[k].rd1;
            vram_ack = vecs[k].ack; din = vecs[k].din; vram_rdata = vecs[k].rdata;
            cyc();
            chk($sformatf("vec%0d_req", k), {63'd0, vram_req}, {63'd0, vecs[k].req});
            if (vecs[k].req) begin
                chk($sformatf("vec%0d_we", k), {63'd0, vram_we}, {63'd0, vecs[k].we});
                chk($sformatf("vec%0d_vaddr", k), 64'(vram_addr), 64'(vecs[k].vaddr));
                if (vecs[k].we) chk($sformatf("vec%0d_wdata", k), 64'(vram_wdata), 64'(vecs[k].wdata));
            end
            chk($sformatf("vec%0d_rd_data", k), 64'(rd_data), 64'(vecs[k].rd));
            chk($sformatf("vec%0d_overrun", k), {63'd0, overrun}, {63'd0, vecs[k].ovr});
            if (vecs[k].ridx >= 0)
                chk($sformatf("vec%0d_reg%0d", k, vecs[k].ridx), 64'(reg_of(vecs[k].ridx)), 64'(vecs[k].rval));
        end

        // rd1 restarts a half-written control pair
        wr1_tick = 1; din = 8'h12; cyc();
        rd1_tick = 1; cyc();
        wr1_tick = 1; din = 8'h9C; cyc();
        wr1_tick = 1; din = 8'h81; cyc();
        chk("rd1_restart_reg1", 64'(reg_of(1)), 64'h9C);
        // rd1 and wr1 together: the write is discarded entirely
        wr1_tick = 1; din = 8'hAA; cyc();
        wr1_tick = 1; rd1_tick = 1; din = 8'h82; cyc();
        chk("rd1_wins_reg2", 64'(reg_of(2)), 64'h00);
        wr1_tick = 1; din = 8'h44; cyc();
        wr1_tick = 1; din = 8'h82; cyc();
        chk("rd1_wins_pair", 64'(reg_of(2)), 64'h44);

        // wr0 and rd0 together: the write wins (address is 0x0523 here)
        wr0_tick = 1; rd0_tick = 1; din = 8'hE1; cyc();
        chk("wr0_rd0_we", {63'd0, vram_we}, 64'd1);
        chk("wr0_rd0_wdata", 64'(vram_wdata), 64'hE1);
        chk("wr0_rd0_vaddr", 64'(vram_addr), 64'h0523);
        vram_ack = 1; cyc();

        // reset while a request is outstanding
        wr0_tick = 1; din = 8'h05; cyc();
        chk("pre_reset_req", {63'd0, vram_req}, 64'd1);
        reset = 1; cyc();
        reset = 0;
        chk("mid_reset_req", {63'd0, vram_req}, 64'd0);
        chk("mid_reset_regs", 64'(regs), 64'd0);
        chk("mid_reset_rd_data", 64'(rd_data), 64'd0);
        chk("mid_reset_overrun", {63'd0, overrun}, 64'd0);
        vram_ack = 1; vram_rdata = 8'hEE; cyc();
        chk("post_reset_ack_req", {63'd0, vram_req}, 64'd0);
        chk("post_reset_ack_rd", 64'(rd_data), 64'd0);

        // randomized traffic against the model
        reset = 1; cyc(); reset = 0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 999) < 4);
            wr0_tick = ($urandom_range(0, 99) < 10);
            rd0_tick = ($urandom_range(0, 99) < 10);
            wr1_tick = ($urandom_range(0, 99) < 30);
            rd1_tick = ($urandom_range(0, 99) < 5);
            din      = 8'($urandom);
            if ($urandom_range(0, 1) == 1) din[5:0] = 6'($urandom_range(0, 9));
            vram_ack   = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
            vram_rdata = m_busy ? mem[m_paddr] : 8'($urandom);
            model_step();
            cyc();
            reset = 0;
            model_compare();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
